// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Brief    : Sequences fetch and load/store accesses onto the unified memory,
//             capturing read data into IR/MDR and pulsing a completion flag.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     FetchReq,
    input  logic [ADDRESS_WIDTH-1:0] PC,
    input  logic                     DataReq,
    input  logic                     DataWe,
    input  logic [ADDRESS_WIDTH-1:0] DataAddr,
    input  logic [DATA_WIDTH-1:0]    DataWData,
    output logic                     Busy,
    output logic                     FetchDone,
    output logic                     DataDone,
    output logic                     AlignErr,
    output logic [DATA_WIDTH-1:0]    IR,
    output logic [DATA_WIDTH-1:0]    MDR,
    output logic [ADDRESS_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0]    WriteData,
    output logic                     MemWrite,
    output logic                     IorD,
    input  logic [DATA_WIDTH-1:0]    MemData
);

    localparam logic [3:0] c_LAST_CNT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } stateT;

    stateT                     r_state;
    stateT                     w_stateNext;
    logic [3:0]                r_count;
    logic [3:0]                w_countNext;
    logic                      r_isStore;
    logic                      w_isStoreNext;
    logic                      r_isData;
    logic                      w_isDataNext;
    logic [ADDRESS_WIDTH-1:0]  w_reqAddr;
    logic                      w_misaligned;
    logic [ADDRESS_WIDTH-1:0]  w_addressNext;
    logic [DATA_WIDTH-1:0]     w_writeDataNext;
    logic [DATA_WIDTH-1:0]     w_irNext;
    logic [DATA_WIDTH-1:0]     w_mdrNext;
    logic                      w_iorDNext;
    logic                      w_memWriteNext;
    logic                      w_fetchDoneNext;
    logic                      w_dataDoneNext;
    logic                      w_alignErrNext;
    logic                      w_busyNext;

    // A data request always wins over a simultaneous fetch.
    assign w_reqAddr    = DataReq ? DataAddr : PC;
    assign w_misaligned = (w_reqAddr[1:0] != 2'b00);

    always_comb begin
        w_stateNext     = r_state;
        w_countNext     = r_count;
        w_isStoreNext   = r_isStore;
        w_isDataNext    = r_isData;
        w_addressNext   = Address;
        w_writeDataNext = WriteData;
        w_iorDNext      = IorD;
        w_irNext        = IR;
        w_mdrNext       = MDR;
        w_memWriteNext  = 1'b0;
        w_fetchDoneNext = 1'b0;
        w_dataDoneNext  = 1'b0;
        w_alignErrNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (DataReq || FetchReq) begin
                    w_isDataNext  = DataReq;
                    w_isStoreNext = DataReq && DataWe;
                    w_addressNext = w_reqAddr;
                    w_iorDNext    = DataReq;
                    w_countNext   = c_LAST_CNT;
                    if (DataReq) begin
                        w_writeDataNext = DataWData;
                    end
                    if (w_misaligned) begin
                        w_stateNext     = DONE;
                        w_alignErrNext  = 1'b1;
                        w_dataDoneNext  = DataReq;
                        w_fetchDoneNext = !DataReq;
                    end else begin
                        w_stateNext    = ACCESS;
                        // Single-cycle memory: the write cycle is the first access cycle.
                        w_memWriteNext = (DataReq && DataWe) && (c_LAST_CNT == 4'd0);
                    end
                end
            end
            ACCESS: begin
                if (r_count == 4'd0) begin
                    w_stateNext = DONE;
                    if (!r_isStore) begin
                        if (r_isData) begin
                            w_mdrNext = MemData;
                        end else begin
                            w_irNext = MemData;
                        end
                    end
                    w_dataDoneNext  = r_isData;
                    w_fetchDoneNext = !r_isData;
                end else begin
                    w_countNext    = r_count - 4'd1;
                    w_memWriteNext = r_isStore && (r_count == 4'd1);
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
        w_busyNext = (w_stateNext != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_count   <= 4'd0;
            r_isStore <= 1'b0;
            r_isData  <= 1'b0;
            Busy      <= 1'b0;
            FetchDone <= 1'b0;
            DataDone  <= 1'b0;
            AlignErr  <= 1'b0;
            IR        <= '0;
            MDR       <= '0;
            Address   <= '0;
            WriteData <= '0;
            MemWrite  <= 1'b0;
            IorD      <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_count   <= w_countNext;
            r_isStore <= w_isStoreNext;
            r_isData  <= w_isDataNext;
            Busy      <= w_busyNext;
            FetchDone <= w_fetchDoneNext;
            DataDone  <= w_dataDoneNext;
            AlignErr  <= w_alignErrNext;
            IR        <= w_irNext;
            MDR       <= w_mdrNext;
            Address   <= w_addressNext;
            WriteData <= w_writeDataNext;
            MemWrite  <= w_memWriteNext;
            IorD      <= w_iorDNext;
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side sequencer that drives the multicycle CPU's unified instruction/data memory. It accepts single-cycle fetch and load/store strobes from the CPU control FSM and drives Address, WriteData, MemWrite and IorD toward the memory for a parameterised number of wait cycles. It captures the returned MemData into the instruction register (IR) or memory data register (MDR) and pulses a completion flag. It sits between the control unit/datapath and the memory block, and is the only master of the memory's input pins.

Parameters:
ADDRESS_WIDTH, 32, width of Address/PC/DataAddr
DATA_WIDTH, 32, width of data, IR and MDR
MEM_LATENCY, 2, memory access cycles per transfer; legal range 1..15

Ports:
Clk  in  1  rising-edge clock
Reset_n  in  1  synchronous, active-low reset
FetchReq  in  1  single-cycle strobe: fetch instruction at PC
PC  in  ADDRESS_WIDTH  fetch address, sampled with FetchReq
DataReq  in  1  single-cycle strobe: data access at DataAddr
DataWe  in  1  with DataReq: 1 = store, 0 = load
DataAddr  in  ADDRESS_WIDTH  data address, sampled with DataReq
DataWData  in  DATA_WIDTH  store data, sampled with DataReq
Busy  out  1  high in every non-IDLE state
FetchDone  out  1  one-cycle pulse: IR updated
DataDone  out  1  one-cycle pulse: MDR updated (load) or store complete
AlignErr  out  1  one-cycle pulse with the Done flag: misaligned request aborted
IR  out  DATA_WIDTH  instruction register
MDR  out  DATA_WIDTH  memory data register
Address  out  ADDRESS_WIDTH  to memory
WriteData  out  DATA_WIDTH  to memory
MemWrite  out  1  to memory; memory writes on a posedge while this is high
IorD  out  1  to memory; 0 = instruction, 1 = data
MemData  in  DATA_WIDTH  from memory

Behaviour:
- Reset (Reset_n=0 at posedge): all outputs 0, state IDLE, counter 0. Applies from any state. An in-flight access is abandoned: MemWrite is low in the cycle after the reset edge, and IR/MDR are cleared.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: strobes sampled only here (Busy=0). If both strobes are high, DataReq wins and FetchReq is dropped; the control FSM never issues both by design.
- Accept (cycle 0): latch address, data, DataWe and kind; set IorD (1 data, 0 fetch); set counter to MEM_LATENCY-1; go to ACCESS.
- Misaligned address (bits [1:0] != 0): no memory access. Go to DONE with AlignErr set. IR/MDR unchanged; MemWrite stays 0.
- ACCESS: Address, IorD and WriteData are held stable for exactly MEM_LATENCY cycles. The counter decrements each cycle.
  - Read: on the edge ending the cycle where counter==0, MemData is captured into IR (fetch) or MDR (load).
  - Store: MemWrite is high only in the counter==0 cycle, giving exactly one write edge.
  - Then go to DONE.
- DONE: exactly one of FetchDone/DataDone is high for 1 cycle, plus AlignErr if flagged. Next state is IDLE. IR/MDR are valid from this cycle onward.
- Latency: accept edge to Done pulse is MEM_LATENCY+1 cycles. Back-to-back accepts occur every MEM_LATENCY+2 cycles.
- Strobes while Busy=1 are ignored: no queuing, no error.
- Address, IorD and WriteData hold their last values in IDLE/DONE. MemWrite is 0 outside the store write cycle.
- IR holds its value until the next fetch completes. MDR holds its value until the next load completes; stores do not alter MDR.

Test Plan:
1. Reset, MEM_LATENCY=2, FetchReq with PC=0x40, memory returns 0x8C010004 -> IorD=0 and Address=0x40 for 2 cycles; FetchDone pulses 3 cycles after accept; IR=0x8C010004; MemWrite never high.
2. DataReq, DataWe=1, DataAddr=0x100, DataWData=0xDEADBEEF -> IorD=1; MemWrite high exactly 1 cycle (the 2nd access cycle); memory word 0x100 reads back 0xDEADBEEF via a following load into MDR; DataDone pulses once for each request.
3. FetchReq and DataReq (load, 0x104) in the same cycle -> only the data access occurs; DataDone pulses; FetchDone never pulses; IR unchanged.
4. DataReq store to 0x102 -> AlignErr and DataDone pulse together 1 cycle after accept; MemWrite stays 0; memory unchanged.
5. Store accepted, Reset_n=0 in the first ACCESS cycle -> MemWrite never asserted; all outputs 0 the next cycle; Busy=0.
6. FetchReq strobed during a Busy load -> ignored; only DataDone pulses; a fetch strobed after return to IDLE completes normally.
